// File: rtl/voice_allocator.sv
`default_nettype none
// =============================================================================
// Module   : voice_allocator
// Purpose  : Assigns note events to voices (match > free > release > steal-LRU).
//            Optional sustain pedal: define VOICE_ALLOCATOR_SUSTAIN_EN.
// Revision : 1.0
// =============================================================================
module voice_allocator #(
    parameter int VOICES        = 4,
    parameter int NOTE_BITS     = 7,
    parameter int RELEASE_TICKS = 48000,
    parameter int TICK_BITS     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    input  logic                        sustain,
`endif
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [NOTE_BITS-1:0]        ev_note,
    output logic [VOICES-1:0]           voice_gate,
    output logic [VOICES-1:0]           voice_trig,
    output logic [VOICES*NOTE_BITS-1:0] voice_note,
    output logic [VOICES-1:0]           voice_busy,
    output logic                        steal
);
    localparam int                   VB       = $clog2(VOICES);
    localparam logic [VB-1:0]        LAST_IDX = VB'(VOICES - 1);
    localparam logic [TICK_BITS-1:0] REL_LOAD = TICK_BITS'(RELEASE_TICKS);

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    typedef enum logic [1:0] {V_IDLE, V_HELD, V_RELEASE, V_SUSTAINED} vstate_t;
`else
    typedef enum logic [1:0] {V_IDLE, V_HELD, V_RELEASE} vstate_t;
`endif
    typedef enum logic [1:0] {C_ACCEPT, C_SCAN, C_COMMIT} ctrl_t;

    // A keyed voice is one whose gate is open; sustained voices behave as held.
    function automatic logic is_keyed(input vstate_t s);
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        return (s == V_HELD) || (s == V_SUSTAINED);
`else
        return s == V_HELD;
`endif
    endfunction

    ctrl_t                  ctrl_q, ctrl_d;
    logic [VB-1:0]          idx_q, idx_d;
    logic                   on_q, on_d;
    logic [NOTE_BITS-1:0]   lnote_q, lnote_d;
    logic                   match_v_q, match_v_d, free_v_q, free_v_d;
    logic                   rel_v_q, rel_v_d, old_v_q, old_v_d;
    logic [VB-1:0]          match_i_q, match_i_d, free_i_q, free_i_d;
    logic [VB-1:0]          rel_i_q, rel_i_d, old_i_q, old_i_d;
    logic [VB-1:0]          rel_r_q, rel_r_d, old_r_q, old_r_d;

    vstate_t                state_q [VOICES];
    vstate_t                state_d [VOICES];
    logic [NOTE_BITS-1:0]   note_q  [VOICES];
    logic [NOTE_BITS-1:0]   note_d  [VOICES];
    logic [TICK_BITS-1:0]   cnt_q   [VOICES];
    logic [TICK_BITS-1:0]   cnt_d   [VOICES];
    logic [VB-1:0]          rank_q  [VOICES];
    logic [VB-1:0]          rank_d  [VOICES];
    logic [VOICES-1:0]      gate_q, gate_d, trig_q, trig_d, busy_q, busy_d;
    logic                   steal_q, steal_d;

    logic                   commit;
    logic [VB-1:0]          pick;
    logic                   do_on, do_off, take_old;
    vstate_t                scan_st;
    logic [NOTE_BITS-1:0]   scan_note;
    logic [VB-1:0]          scan_rank;

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic sus_q;
    logic sus_fall;
    assign sus_fall = sus_q & ~sustain;
    always_ff @(posedge clk) begin
        if (rst) sus_q <= 1'b0;
        else     sus_q <= sustain;
    end
`endif

    assign scan_st   = state_q[idx_q];
    assign scan_note = note_q[idx_q];
    assign scan_rank = rank_q[idx_q];
    assign ev_ready  = (ctrl_q == C_ACCEPT);

    always_comb begin
        ctrl_d    = ctrl_q;
        idx_d     = idx_q;
        on_d      = on_q;
        lnote_d   = lnote_q;
        match_v_d = match_v_q;
        match_i_d = match_i_q;
        free_v_d  = free_v_q;
        free_i_d  = free_i_q;
        rel_v_d   = rel_v_q;
        rel_i_d   = rel_i_q;
        rel_r_d   = rel_r_q;
        old_v_d   = old_v_q;
        old_i_d   = old_i_q;
        old_r_d   = old_r_q;
        commit    = 1'b0;
        case (ctrl_q)
            C_ACCEPT: begin
                if (ev_valid) begin
                    on_d      = ev_on;
                    lnote_d   = ev_note;
                    idx_d     = '0;
                    match_v_d = 1'b0;
                    free_v_d  = 1'b0;
                    rel_v_d   = 1'b0;
                    old_v_d   = 1'b0;
                    ctrl_d    = C_SCAN;
                end
            end
            C_SCAN: begin
                if (is_keyed(scan_st) && (scan_note == lnote_q) && !match_v_q) begin
                    match_v_d = 1'b1;
                    match_i_d = idx_q;
                end
                if ((scan_st == V_IDLE) && !free_v_q) begin
                    free_v_d = 1'b1;
                    free_i_d = idx_q;
                end
                if ((scan_st == V_RELEASE) && (!rel_v_q || (scan_rank > rel_r_q))) begin
                    rel_v_d = 1'b1;
                    rel_i_d = idx_q;
                    rel_r_d = scan_rank;
                end
                if (is_keyed(scan_st) && (!old_v_q || (scan_rank > old_r_q))) begin
                    old_v_d = 1'b1;
                    old_i_d = idx_q;
                    old_r_d = scan_rank;
                end
                if (idx_q == LAST_IDX) ctrl_d = C_COMMIT;
                else                   idx_d  = idx_q + VB'(1);
            end
            C_COMMIT: begin
                commit = 1'b1;
                ctrl_d = C_ACCEPT;
            end
            default: ctrl_d = C_ACCEPT;
        endcase
    end

    always_comb begin
        pick     = old_i_q;
        take_old = 1'b0;
        if (match_v_q)     pick = match_i_q;
        else if (free_v_q) pick = free_i_q;
        else if (rel_v_q)  pick = rel_i_q;
        else               take_old = old_v_q;
        do_on   = commit & on_q;
        do_off  = commit & ~on_q & match_v_q;
        steal_d = do_on & take_old;
    end

    // Commit writes come last so they override a same-cycle release tick.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            state_d[i] = state_q[i];
            note_d[i]  = note_q[i];
            cnt_d[i]   = cnt_q[i];
            rank_d[i]  = rank_q[i];
            trig_d[i]  = 1'b0;
            if (sample_tick && (state_q[i] == V_RELEASE)) begin
                if (cnt_q[i] <= TICK_BITS'(1)) begin
                    state_d[i] = V_IDLE;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - TICK_BITS'(1);
                end
            end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            if (sus_fall && (state_q[i] == V_SUSTAINED)) begin
                state_d[i] = V_RELEASE;
                cnt_d[i]   = REL_LOAD;
            end
`endif
            if (do_on) begin
                if (pick == VB'(i)) begin
                    state_d[i] = V_HELD;
                    note_d[i]  = lnote_q;
                    trig_d[i]  = 1'b1;
                    rank_d[i]  = '0;
                end else if (rank_q[i] < rank_q[pick]) begin
                    rank_d[i] = rank_q[i] + VB'(1);
                end
            end
            if (do_off && (pick == VB'(i))) begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                state_d[i] = sustain ? V_SUSTAINED : V_RELEASE;
`else
                state_d[i] = V_RELEASE;
`endif
                cnt_d[i] = REL_LOAD;
            end
            gate_d[i] = is_keyed(state_d[i]);
            busy_d[i] = (state_d[i] != V_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= C_ACCEPT;
            idx_q     <= '0;
            on_q      <= 1'b0;
            lnote_q   <= '0;
            match_v_q <= 1'b0;
            match_i_q <= '0;
            free_v_q  <= 1'b0;
            free_i_q  <= '0;
            rel_v_q   <= 1'b0;
            rel_i_q   <= '0;
            rel_r_q   <= '0;
            old_v_q   <= 1'b0;
            old_i_q   <= '0;
            old_r_q   <= '0;
            gate_q    <= '0;
            trig_q    <= '0;
            busy_q    <= '0;
            steal_q   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= V_IDLE;
                note_q[i]  <= '0;
                cnt_q[i]   <= '0;
                rank_q[i]  <= VB'(i);
            end
        end else begin
            ctrl_q    <= ctrl_d;
            idx_q     <= idx_d;
            on_q      <= on_d;
            lnote_q   <= lnote_d;
            match_v_q <= match_v_d;
            match_i_q <= match_i_d;
            free_v_q  <= free_v_d;
            free_i_q  <= free_i_d;
            rel_v_q   <= rel_v_d;
            rel_i_q   <= rel_i_d;
            rel_r_q   <= rel_r_d;
            old_v_q   <= old_v_d;
            old_i_q   <= old_i_d;
            old_r_q   <= old_r_d;
            gate_q    <= gate_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            steal_q   <= steal_d;
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= state_d[i];
                note_q[i]  <= note_d[i];
                cnt_q[i]   <= cnt_d[i];
                rank_q[i]  <= rank_d[i];
            end
        end
    end

    assign voice_gate = gate_q;
    assign voice_trig = trig_q;
    assign voice_busy = busy_q;
    assign steal      = steal_q;

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_note
            assign voice_note[gi*NOTE_BITS +: NOTE_BITS] = note_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire
